memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
// Pipeline stage between execute and writeback in the 5-stage CPU. Registers execute results
// and runs data-RAM loads/stores over a req/ack handshake that tolerates variable latency.
// Aligns store bytes and extracts/extends load bytes, then hands wen, dest reg, ALU result,
// load data and an is_load flag to writeback. Stalls execute while an access is outstanding.
// PARAMETERS
// ADDR_W  32  data-RAM byte-address width; data path fixed at 32 bits
// RF_AW   5   register-file index width
// PORTS
// clk             in   1       clock, rising edge
// resetn          in   1       asynchronous, active-low reset
// exe_valid       in   1       execute presents an instruction this cycle
// exe_wen         in   1       instruction writes the register file
// exe_regsrc      in   RF_AW   destination register
// exe_alu_result  in   32      ALU result; effective address for loads/stores
// exe_store_data  in   32      rt value for stores
// exe_is_load     in   1       load instruction
// exe_is_store    in   1       store instruction
// exe_mem_size    in   2       00 byte, 01 half, 10 word (11 reserved, treated as word)
// exe_mem_unsigned in  1       zero-extend load (lbu/lhu)
// mem_allowin     out  1       execute may hand over an instruction this cycle
// dram_req        out  1       access request, held until acked
// dram_we         out  1       1 store, 0 load
// dram_addr       out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
// dram_wstrb      out  4       byte enables for stores; 0 for loads
// dram_wdata      out  32      store data, lane-replicated
// dram_ack        in   1       access complete; rdata valid in the same cycle for loads
// dram_rdata      in   32      load word
// mem_valid       out  1       one-cycle pulse: result is valid for writeback
// mem_wen         out  1       to writeback; 0 unless mem_valid
// mem_regsrc      out  RF_AW   to writeback
// mem_alu_result  out  32      registered ALU result, to writeback
// mem_load_data   out  32      aligned and extended load data
// mem_is_load     out  1       writeback selects mem_load_data
// mem_excp        out  1       misaligned access flag, qualified by mem_valid
// BEHAVIOUR
// - Reset: all outputs 0 except mem_allowin=1; state IDLE. resetn low mid-access drops dram_req
//   immediately and discards the instruction.
// - FSM IDLE / ACCESS / DONE. mem_allowin = (state != ACCESS).
// - Capture happens at the edge where exe_valid & mem_allowin. Memory op -> ACCESS; other op -> DONE.
//   No capture: DONE -> IDLE.
// - ACCESS: dram_req=1 with addr/we/wstrb/wdata stable. At the edge with dram_ack=1, latch the
//   extracted load data and move to DONE. dram_ack outside ACCESS is ignored.
// - DONE: mem_valid=1 for exactly one cycle. A new capture in DONE is allowed (back-to-back).
// - Latency from capture edge: non-memory op -> mem_valid next cycle. Memory op -> mem_valid
//   in the cycle after the ack cycle, so a 0-wait ack gives 2 cycles.
// - Misaligned access (half with a[0]=1, or word with a[1:0]!=0): no dram_req, go to DONE with
//   mem_excp=1 and mem_wen forced 0.
// - Store strobes: byte -> 4'b0001<<a[1:0], wdata={4{d[7:0]}}; half -> a[1]?1100:0011,
//   wdata={2{d[15:0]}}; word -> 1111.
// - Load extract: byte lane a[1:0], half lane a[1], then sign- or zero-extend to 32 bits.
// - A load or store with exe_wen set is honoured as given. A store never asserts mem_wen,
//   whatever exe_wen says.
// STRUCTURE
// - cpu_pkg holds the mem_size encodings (MEM_B/MEM_H/MEM_W) and the state enum IDLE/ACCESS/DONE.
// - Sub-module mem_align (combinational) produces wstrb/wdata from size/addr/data and load data
//   from rdata/size/addr/unsigned.
// TESTING
// - ALU op, exe_alu_result=0x1234, regsrc=5, wen=1 -> next cycle mem_valid=1, mem_wen=1,
//   mem_alu_result=0x1234, no dram_req.
// - lb at 0x103, rdata=0x80FF_FF7F, ack 3 cycles later -> allowin=0 for 3 cycles;
//   mem_load_data=0xFFFFFF80; lbu gives 0x00000080.
// - sh at 0x102, data=0xABCD -> dram_addr=0x100, wstrb=1100, wdata=0xABCDABCD, mem_wen=0.
// - lw at 0x102 -> no dram_req; next cycle mem_valid=1, mem_excp=1, mem_wen=0.
// - Back-to-back lw/lw with 0-wait ack -> each mem_valid 2 cycles after its capture, with no
//   dropped or duplicated pulse.
// - resetn low while in ACCESS -> dram_req=0 asynchronously; after release mem_valid stays 0 and
//   the late ack is ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the memory stage: access sizes, FSM states, alignment rule.
// No logic of its own; imported by memory_stage and mem_align.
// Size code 2'b11 is reserved and is handled everywhere as a word access.
package cpu_pkg;

    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Halfwords need an even address; words (and the reserved code) need a[1:0]==0.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        logic m;
        case (size)
            MEM_B:   m = 1'b0;
            MEM_H:   m = a[0];
            default: m = (a != 2'b00);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Purpose: store byte-lane strobes/replicated data and load lane extraction with extension.
// Latency: purely combinational.
// Backpressure: none; the caller decides when outputs are used.
// Ports: size/addr_lo select the lanes, sdata is the store value, rdata the fetched word,
//        is_unsigned picks zero- vs sign-extension; wstrb/wdata/ldata are the results.
module mem_align
    import cpu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] sdata,
    input  logic [31:0] rdata,
    input  logic        is_unsigned,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] ldata
);

    logic [7:0]  lbyte;
    logic [15:0] lhalf;

    always_comb begin
        lbyte = rdata[{addr_lo, 3'b000} +: 8];
        lhalf = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        wstrb = 4'b1111;
        wdata = sdata;
        ldata = rdata;
        case (size)
            MEM_B: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{sdata[7:0]}};
                ldata = {{24{~is_unsigned & lbyte[7]}}, lbyte};
            end
            MEM_H: begin
                wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{sdata[15:0]}};
                ldata = {{16{~is_unsigned & lhalf[15]}}, lhalf};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Purpose: execute->writeback pipeline register that also performs data-RAM loads/stores.
// Latency: non-memory op 1 cycle; memory op 1 cycle after the dram_ack cycle (min 2).
// Backpressure: mem_allowin low while an access waits for dram_ack; no writeback stall.
// Ports: exe_* capture side, dram_* req/ack RAM side, mem_* one-cycle result pulse to writeback.
module memory_stage
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int RF_AW  = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              exe_valid,
    input  logic              exe_wen,
    input  logic [RF_AW-1:0]  exe_regsrc,
    input  logic [31:0]       exe_alu_result,
    input  logic [31:0]       exe_store_data,
    input  logic              exe_is_load,
    input  logic              exe_is_store,
    input  logic [1:0]        exe_mem_size,
    input  logic              exe_mem_unsigned,
    output logic              mem_allowin,
    output logic              dram_req,
    output logic              dram_we,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [3:0]        dram_wstrb,
    output logic [31:0]       dram_wdata,
    input  logic              dram_ack,
    input  logic [31:0]       dram_rdata,
    output logic              mem_valid,
    output logic              mem_wen,
    output logic [RF_AW-1:0]  mem_regsrc,
    output logic [31:0]       mem_alu_result,
    output logic [31:0]       mem_load_data,
    output logic              mem_is_load,
    output logic              mem_excp
);

    state_t             state, state_nxt;
    logic               r_wen, r_is_load, r_is_store, r_unsigned, r_excp;
    logic [RF_AW-1:0]   r_regsrc;
    logic [31:0]        r_alu, r_sdata, r_ldata;
    logic [1:0]         r_size;
    logic               capture, in_mem_op, in_misaligned;
    logic [3:0]         al_wstrb;
    logic [31:0]        al_wdata, al_ldata;

    assign mem_allowin   = (state != ACCESS);
    assign capture       = exe_valid & mem_allowin;
    assign in_mem_op     = exe_is_load | exe_is_store;
    assign in_misaligned = in_mem_op & misaligned(exe_mem_size, exe_alu_result[1:0]);

    // Misaligned accesses never touch the RAM; they go straight to DONE with the flag set.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (capture)
                    state_nxt = (in_mem_op & ~in_misaligned) ? ACCESS : DONE;
                else
                    state_nxt = IDLE;
            end
            ACCESS:  if (dram_ack) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            r_wen      <= 1'b0;
            r_regsrc   <= '0;
            r_alu      <= '0;
            r_sdata    <= '0;
            r_is_load  <= 1'b0;
            r_is_store <= 1'b0;
            r_size     <= MEM_B;
            r_unsigned <= 1'b0;
            r_excp     <= 1'b0;
            r_ldata    <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                r_wen      <= exe_wen;
                r_regsrc   <= exe_regsrc;
                r_alu      <= exe_alu_result;
                r_sdata    <= exe_store_data;
                r_is_load  <= exe_is_load;
                r_is_store <= exe_is_store;
                r_size     <= exe_mem_size;
                r_unsigned <= exe_mem_unsigned;
                r_excp     <= in_misaligned;
            end
            // Only an ack seen while waiting counts; strays in other states are dropped.
            if (state == ACCESS && dram_ack && r_is_load)
                r_ldata <= al_ldata;
        end
    end

    mem_align u_align (
        .size        (r_size),
        .addr_lo     (r_alu[1:0]),
        .sdata       (r_sdata),
        .rdata       (dram_rdata),
        .is_unsigned (r_unsigned),
        .wstrb       (al_wstrb),
        .wdata       (al_wdata),
        .ldata       (al_ldata)
    );

    // RAM-side outputs are all derived from the state register so reset clears them at once.
    assign dram_req   = (state == ACCESS);
    assign dram_we    = dram_req & r_is_store;
    assign dram_addr  = dram_req ? {r_alu[ADDR_W-1:2], 2'b00} : '0;
    assign dram_wstrb = dram_we ? al_wstrb : 4'b0000;
    assign dram_wdata = dram_we ? al_wdata : 32'h0;

    assign mem_valid      = (state == DONE);
    assign mem_wen        = mem_valid & r_wen & ~r_is_store & ~r_excp;
    assign mem_excp       = mem_valid & r_excp;
    assign mem_regsrc     = r_regsrc;
    assign mem_alu_result = r_alu;
    assign mem_load_data  = r_ldata;
    assign mem_is_load    = r_is_load;

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        exe_valid = 1'b0, exe_wen = 1'b0, exe_is_load = 1'b0, exe_is_store = 1'b0;
    logic        exe_mem_unsigned = 1'b0;
    logic [4:0]  exe_regsrc = '0;
    logic [31:0] exe_alu_result = '0, exe_store_data = '0;
    logic [1:0]  exe_mem_size = '0;
    logic        mem_allowin, dram_req, dram_we, mem_valid, mem_wen, mem_is_load, mem_excp;
    logic [31:0] dram_addr, dram_wdata, mem_alu_result, mem_load_data;
    logic [3:0]  dram_wstrb;
    logic        dram_ack = 1'b0;
    logic [31:0] dram_rdata = '0;
    logic [4:0]  mem_regsrc;

    memory_stage #(.ADDR_W(32), .RF_AW(5)) dut (
        .clk(clk), .resetn(resetn),
        .exe_valid(exe_valid), .exe_wen(exe_wen), .exe_regsrc(exe_regsrc),
        .exe_alu_result(exe_alu_result), .exe_store_data(exe_store_data),
        .exe_is_load(exe_is_load), .exe_is_store(exe_is_store),
        .exe_mem_size(exe_mem_size), .exe_mem_unsigned(exe_mem_unsigned),
        .mem_allowin(mem_allowin),
        .dram_req(dram_req), .dram_we(dram_we), .dram_addr(dram_addr),
        .dram_wstrb(dram_wstrb), .dram_wdata(dram_wdata),
        .dram_ack(dram_ack), .dram_rdata(dram_rdata),
        .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_regsrc(mem_regsrc),
        .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
        .mem_is_load(mem_is_load), .mem_excp(mem_excp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic        is_load;
        logic        excp;
        logic [31:0] ldata;
        bit          is_mem;
        int          cap;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } dexp_t;

    exp_t  sq[$];
    dexp_t dq[$];
    int    n_chk = 0, n_fail = 0;
    int    cyc = 0, ack_cyc = 0;
    int    fixed_delay = -1;
    bit    hold_ack = 0, late_ack = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RAM contents seen by the responder and by the model alike.
    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        logic [31:0] wa;
        wa = a & 32'hFFFF_FFFC;
        if (wa == 32'h100) return 32'h80FF_FF7F;
        return (wa >> 2) * 32'h9E37_79B1 ^ 32'h5A5A_C3C3;
    endfunction

    // Reference model: expected writeback result and RAM transaction for one instruction.
    task automatic model(input bit ld, input bit st, input bit wen, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                         input bit uns);
        exp_t        e;
        dexp_t       x;
        logic [31:0] w, v;
        int          sh;
        bit          mis;
        sh  = int'(a[1:0]);
        mis = (ld || st) && ((sz == 2'd1 && (sh % 2) != 0) || (sz >= 2'd2 && sh != 0));
        w   = rdata_of(a);
        case (sz)
            2'd0: begin
                v = (w >> (8 * sh)) & 32'hFF;
                if (!uns) v = v - ((v & 32'h80) << 1);
            end
            2'd1: begin
                v = (w >> (8 * (sh / 2) * 2)) & 32'hFFFF;
                if (!uns) v = v - ((v & 32'h8000) << 1);
            end
            default: v = w;
        endcase
        e.wen = wen && !st && !mis;
        e.rd = rd; e.alu = a; e.is_load = ld; e.excp = mis; e.ldata = v;
        e.is_mem = ld || st; e.cap = cyc + 1;
        sq.push_back(e);
        if ((ld || st) && !mis) begin
            x.addr = a & 32'hFFFF_FFFC;
            x.we = st;
            x.wstrb = 4'b0000;
            x.wdata = d;
            if (st) begin
                case (sz)
                    2'd0: begin x.wstrb = 4'(1 << sh); x.wdata = (d & 32'hFF) * 32'h0101_0101; end
                    2'd1: begin x.wstrb = (sh >= 2) ? 4'b1100 : 4'b0011;
                                x.wdata = (d & 32'hFFFF) * 32'h0001_0001; end
                    default: x.wstrb = 4'b1111;
                endcase
            end
            dq.push_back(x);
        end
    endtask

    task automatic issue(input bit ld, input bit st, input bit wen, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                         input bit uns, input bit push);
        int n;
        @(negedge clk);
        exe_valid = 1; exe_is_load = ld; exe_is_store = st; exe_wen = wen; exe_regsrc = rd;
        exe_alu_result = a; exe_store_data = d; exe_mem_size = sz; exe_mem_unsigned = uns;
        n = 0;
        while (!mem_allowin && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!mem_allowin) begin
            check("allowin_timeout", mem_allowin, 1);
            exe_valid = 0;
        end else if (push) begin
            model(ld, st, wen, rd, a, d, sz, uns);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        exe_valid = 0; exe_wen = $urandom; exe_is_load = $urandom; exe_is_store = $urandom;
        exe_alu_result = $urandom;
    endtask

    // RAM responder: checks each new request, holds it for a random wait, then acks.
    logic  prev_req = 0;
    int    wait_left = 0;
    dexp_t cur;
    always @(negedge clk) begin
        dram_ack = 0;
        dram_rdata = $urandom;
        if (dram_req) begin
            if (!prev_req) begin
                wait_left = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                cur.addr = dram_addr; cur.we = dram_we; cur.wstrb = dram_wstrb;
                cur.wdata = dram_wdata;
                if (!hold_ack) begin
                    if (dq.size() == 0) check("unexpected_dram_req", dram_req, 0);
                    else begin
                        dexp_t x;
                        x = dq.pop_front();
                        check("dram_addr", dram_addr, x.addr);
                        check("dram_we", dram_we, x.we);
                        check("dram_wstrb", dram_wstrb, x.wstrb);
                        if (x.we) check("dram_wdata", dram_wdata, x.wdata);
                    end
                end
            end else begin
                check("dram_addr_stable", dram_addr, cur.addr);
                check("dram_wstrb_stable", dram_wstrb, cur.wstrb);
            end
            if (!hold_ack && wait_left == 0) begin
                dram_ack = 1;
                dram_rdata = rdata_of(dram_addr);
                ack_cyc = cyc + 1;
            end else if (wait_left > 0) begin
                wait_left--;
            end
        end else if (late_ack || $urandom_range(0, 3) == 0) begin
            dram_ack = 1;
        end
        prev_req = dram_req;
    end

    // Monitor: pops one expectation per mem_valid pulse.
    always @(negedge clk) begin
        if (resetn) begin
            if (mem_valid) begin
                if (sq.size() == 0) check("spurious_mem_valid", mem_valid, 0);
                else begin
                    exp_t e;
                    e = sq.pop_front();
                    check("mem_wen", mem_wen, e.wen);
                    check("mem_regsrc", mem_regsrc, e.rd);
                    check("mem_alu_result", mem_alu_result, e.alu);
                    check("mem_is_load", mem_is_load, e.is_load);
                    check("mem_excp", mem_excp, e.excp);
                    if (e.is_load && !e.excp) check("mem_load_data", mem_load_data, e.ldata);
                    check("latency", cyc, (e.is_mem && !e.excp) ? ack_cyc : e.cap);
                end
            end else begin
                check("idle_wen_excp", {mem_wen, mem_excp}, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bit ld, st;
        logic [31:0] a;
        // Reset state
        @(negedge clk);
        check("rst_allowin", mem_allowin, 1);
        check("rst_dram_req", dram_req, 0);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_mem_wen", mem_wen, 0);
        check("rst_mem_alu_result", mem_alu_result, 0);
        check("rst_mem_load_data", mem_load_data, 0);
        resetn = 1;

        // Directed cases
        issue(0, 0, 1, 5, 32'h1234, 0, 2'd0, 0, 1);
        fixed_delay = 2;
        issue(1, 0, 1, 7, 32'h103, 0, 2'd0, 0, 1);
        issue(1, 0, 1, 8, 32'h103, 0, 2'd0, 1, 1);
        fixed_delay = -1;
        issue(0, 1, 1, 9, 32'h102, 32'h0000_ABCD, 2'd1, 0, 1);
        issue(1, 0, 1, 10, 32'h102, 0, 2'd2, 0, 1);
        fixed_delay = 0;
        issue(1, 0, 1, 11, 32'h100, 0, 2'd2, 0, 1);
        issue(1, 0, 1, 12, 32'h104, 0, 2'd2, 0, 1);
        fixed_delay = -1;

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            else begin
                n  = $urandom_range(0, 2);
                ld = (n == 1); st = (n == 2);
                a  = $urandom;
                if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
                if ($urandom_range(0, 2) == 0) a[31:8] = 24'h000001;
                issue(ld, st, $urandom, 5'($urandom), a, $urandom, 2'($urandom), $urandom, 1);
            end
        end

        // Drain
        idle();
        n = 0;
        while ((sq.size() != 0 || mem_valid) && n < 200) begin
            idle();
            n++;
        end
        check("drain_scoreboard", sq.size(), 0);
        check("drain_dram_queue", dq.size(), 0);

        // Reset while an access is outstanding
        hold_ack = 1;
        issue(1, 0, 1, 3, 32'h200, 0, 2'd2, 0, 0);
        @(negedge clk);
        exe_valid = 0;
        check("rst_test_req_pending", dram_req, 1);
        #2 resetn = 0;
        #1;
        check("async_rst_drops_req", dram_req, 0);
        check("async_rst_allowin", mem_allowin, 1);
        @(negedge clk);
        resetn = 1;
        hold_ack = 0;
        late_ack = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_no_valid", mem_valid, 0);
            check("post_rst_no_req", dram_req, 0);
        end
        late_ack = 0;

        // Normal operation resumes
        issue(0, 0, 1, 21, 32'hCAFE_0001, 0, 2'd0, 0, 1);
        idle();
        n = 0;
        while (sq.size() != 0 && n < 50) begin
            idle();
            n++;
        end
        check("final_scoreboard", sq.size(), 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
